// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one multi-cycle multiplier among N_REQ requesters.
// Optional WAIT-state timeout is built only when MUL_ARB_TIMEOUT_EN is defined.
module mul_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int OP_W      = 24,
    parameter int RES_W     = 48,
    parameter int FLUSH_CYC = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*OP_W-1:0] a_in,
    input  logic [N_REQ*OP_W-1:0] b_in,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [RES_W-1:0]      result,
    output logic                  err,
    output logic                  busy,
    output logic                  mul_start,
    output logic [OP_W-1:0]       mul_a,
    output logic [OP_W-1:0]       mul_b,
    input  logic                  mul_ready,
    input  logic [RES_W-1:0]      mul_result
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int FC_W  = $clog2(FLUSH_CYC + 1);

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || RES_W != 2 * OP_W || FLUSH_CYC < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mul_share_arbiter: illegal parameter combination");
    end

    state_t               state_r, state_nx_s;
    logic [FC_W-1:0]      fcnt_r, fcnt_nx_s;
    logic [IDX_W-1:0]     rr_r, rr_nx_s;
    logic [IDX_W-1:0]     gidx_r, gidx_nx_s;
    logic [IDX_W:0]       pick_s;
    logic [N_REQ-1:0]     gnt_r, gnt_nx_s;
    logic [N_REQ-1:0]     done_r, done_nx_s;
    logic [RES_W-1:0]     result_r, result_nx_s;
    logic                 start_r, start_nx_s;
    logic [OP_W-1:0]      mul_a_r, a_nx_s;
    logic [OP_W-1:0]      mul_b_r, b_nx_s;
    logic                 busy_r;
    logic                 tmo_hit_s;
    logic                 rsp_err_s;

    // First requester at or after ptr, wrapping; MSB flags that one was found.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] sel;
        int             j;
        sel = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (r[j[IDX_W-1:0]]) begin
                sel = {1'b1, IDX_W'(j)};
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign pick_s = rr_pick(req, rr_r);

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt_r;
    logic          err_r;

    assign tmo_hit_s = (wcnt_r == TW'(TIMEOUT - 1));
    assign rsp_err_s = err_r;
    assign err       = err_r;

    // WAIT dwell counter and timeout flag, which is high only in the RESP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r <= '0;
            err_r  <= 1'b0;
        end else begin
            if (state_r == ST_WAIT) begin
                wcnt_r <= wcnt_r + TW'(1);
            end else begin
                wcnt_r <= '0;
            end
            err_r <= (state_r == ST_WAIT) && !mul_ready && tmo_hit_s;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign rsp_err_s = 1'b0;
    assign err       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FLUSH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; mul_ready only matters in WAIT
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FLUSH: begin
                if (fcnt_r == FC_W'(FLUSH_CYC - 1)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nx_s = ST_WAIT;
            ST_WAIT: begin
                if (mul_ready || tmo_hit_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_err_s) begin
                    state_nx_s = ST_FLUSH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_FLUSH;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        gnt_nx_s    = gnt_r;
        done_nx_s   = '0;
        result_nx_s = result_r;
        start_nx_s  = 1'b0;
        a_nx_s      = mul_a_r;
        b_nx_s      = mul_b_r;
        gidx_nx_s   = gidx_r;
        rr_nx_s     = rr_r;
        fcnt_nx_s   = '0;
        case (state_r)
            ST_FLUSH: fcnt_nx_s = fcnt_r + FC_W'(1);
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    gnt_nx_s   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s[IDX_W-1:0];
                    gidx_nx_s  = pick_s[IDX_W-1:0];
                    a_nx_s     = a_in[pick_s[IDX_W-1:0]*OP_W +: OP_W];
                    b_nx_s     = b_in[pick_s[IDX_W-1:0]*OP_W +: OP_W];
                    start_nx_s = 1'b1;
                end else begin
                    gnt_nx_s = '0;
                end
            end
            ST_ISSUE: start_nx_s = 1'b0;
            ST_WAIT: begin
                if (mul_ready) begin
                    result_nx_s = mul_result;
                    done_nx_s   = gnt_r;
                end else if (tmo_hit_s) begin
                    result_nx_s = '0;
                    done_nx_s   = gnt_r;
                end else begin
                    done_nx_s = '0;
                end
            end
            ST_RESP: begin
                gnt_nx_s = '0;
                rr_nx_s  = (gidx_r == IDX_W'(N_REQ - 1)) ? '0 : gidx_r + IDX_W'(1);
            end
            default: begin
                gnt_nx_s = '0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r    <= '0;
            done_r   <= '0;
            result_r <= '0;
            start_r  <= 1'b0;
            mul_a_r  <= '0;
            mul_b_r  <= '0;
            gidx_r   <= '0;
            rr_r     <= '0;
            fcnt_r   <= '0;
            busy_r   <= 1'b1;
        end else begin
            gnt_r    <= gnt_nx_s;
            done_r   <= done_nx_s;
            result_r <= result_nx_s;
            start_r  <= start_nx_s;
            mul_a_r  <= a_nx_s;
            mul_b_r  <= b_nx_s;
            gidx_r   <= gidx_nx_s;
            rr_r     <= rr_nx_s;
            fcnt_r   <= fcnt_nx_s;
            busy_r   <= (state_nx_s != ST_IDLE);
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign result    = result_r;
    assign mul_start = start_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a 5-cycle multiplier model.
`timescale 1ns/1ps
module tb_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [95:0] a_in = 96'd0;
    logic [95:0] b_in = 96'd0;
    logic [3:0]  gnt, done;
    logic [47:0] result;
    logic        err, busy, mul_start;
    logic [23:0] mul_a, mul_b;
    logic        mul_ready = 1'b0;
    logic [47:0] mul_result;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  d;
        logic [47:0] r;
        logic        er;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .N_REQ(4), .OP_W(24), .RES_W(48), .FLUSH_CYC(8), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_result(mul_result)
    );

    // Multiplier model: no reset, ready 5 cycles after start; can be silenced or forced
    int          lat_cnt = 0;
    bit          mul_dead = 1'b0;
    bit          inject = 1'b0;
    logic [47:0] prod = 48'd0;
    always @(posedge clk) begin
        mul_ready <= 1'b0;
        if (inject) begin
            mul_ready <= 1'b1;
        end else if (mul_start && !mul_dead) begin
            lat_cnt <= 4;
            prod    <= 48'(mul_a) * 48'(mul_b);
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) mul_ready <= 1'b1;
        end
    end
    assign mul_result = prod;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] d, input logic [47:0] r, input logic er);
        exp_t x;
        x.d = d; x.r = r; x.er = er;
        return x;
    endfunction

    // Monitor: pops the scoreboard on every done pulse
    int start_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                start_cnt = 0;
            end else begin
                if (mul_start) start_cnt++;
                if (gnt != 4'b0000) chk("gnt_onehot", {63'b0, $onehot(gnt)}, 64'd1);
                if (err && done == 4'b0000) chk("err_without_done", {63'b0, err}, 64'd0);
                if (done != 4'b0000) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", {60'b0, done}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done", {60'b0, done}, {60'b0, e.d});
                        chk("result", {16'b0, result}, {16'b0, e.r});
                        chk("err", {63'b0, err}, {63'b0, e.er});
                        chk("starts_per_op", 64'(start_cnt), 64'd1);
                    end
                    start_cnt = 0;
                end
            end
        end
    end

    // Checks the 8 FLUSH cycles starting at the current negedge, then IDLE
    task automatic flush_check(input int inj_at);
        for (int k = 0; k < 8; k++) begin
            inject = (k == inj_at);
            chk("flush_busy", {63'b0, busy}, 64'd1);
            chk("flush_gnt", {60'b0, gnt}, 64'd0);
            chk("flush_done", {60'b0, done}, 64'd0);
            @(negedge clk);
        end
        inject = 1'b0;
        chk("flush_end_idle", {63'b0, busy}, 64'd0);
        chk("flush_end_gnt", {60'b0, gnt}, 64'd0);
    endtask

    task automatic do_reset(input int inj_at);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flush_check(inj_at);
    endtask

    task automatic wait_gnt(input logic [3:0] g, output int lat);
        lat = 0;
        while (gnt !== g && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("gnt_wait", {60'b0, gnt}, {60'b0, g});
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done == 4'b0000 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {63'b0, (done != 4'b0000)}, 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, n, k, g2;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {60'b0, gnt}, 64'd0);
        chk("rst_done", {60'b0, done}, 64'd0);
        chk("rst_result", {16'b0, result}, 64'd0);
        chk("rst_err", {63'b0, err}, 64'd0);
        chk("rst_start", {63'b0, mul_start}, 64'd0);
        chk("rst_mul_a", {40'b0, mul_a}, 64'd0);
        chk("rst_mul_b", {40'b0, mul_b}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd1);

        // First operation straight out of reset: 3*5
        req = 4'b0001;
        a_in[0 +: 24] = 24'h000003;
        b_in[0 +: 24] = 24'h000005;
        sb.push_back(mk(4'b0001, 48'h00000000000F, 1'b0));
        rst_n = 1'b1;
        flush_check(-1);
        wait_gnt(4'b0001, lat);
        chk("first_grant_delay", 64'(lat), 64'd1);
        chk("first_start", {63'b0, mul_start}, 64'd1);
        wait_done(lat);
        chk("latency", 64'(lat), 64'd6);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("result_hold", {16'b0, result}, 64'h00000000000F);

        // All-ones request: rotation 0,1,2,3,0
        do_reset(-1);
        for (int i = 0; i < 4; i++) begin
            a_in[i*24 +: 24] = 24'(i + 1);
            b_in[i*24 +: 24] = 24'd2;
        end
        sb.push_back(mk(4'b0001, 48'd2, 1'b0));
        sb.push_back(mk(4'b0010, 48'd4, 1'b0));
        sb.push_back(mk(4'b0100, 48'd6, 1'b0));
        sb.push_back(mk(4'b1000, 48'd8, 1'b0));
        sb.push_back(mk(4'b0001, 48'd2, 1'b0));
        req = 4'b1111;
        n = 0;
        k = 0;
        while (n < 5 && k < 100) begin
            @(negedge clk);
            k++;
            if (done != 4'b0000) n++;
        end
        req = 4'b0000;
        chk("rr_done_count", 64'(n), 64'd5);
        repeat (3) @(negedge clk);

        // Operand hold while requester scribbles its inputs
        a_in[24 +: 24] = 24'h000123;
        b_in[24 +: 24] = 24'h000456;
        sb.push_back(mk(4'b0010, 48'h000000004EDC2, 1'b0));
        req = 4'b0010;
        wait_gnt(4'b0010, lat);
        req = 4'b0000;
        @(negedge clk);
        a_in[24 +: 24] = 24'hFFFFFF;
        b_in[24 +: 24] = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            chk("hold_mul_a", {40'b0, mul_a}, 64'h123);
            chk("hold_mul_b", {40'b0, mul_b}, 64'h456);
            @(negedge clk);
        end
        wait_done(lat);
        repeat (3) @(negedge clk);

        // Reset mid-WAIT with a stale ready shortly after release
        mul_dead = 1'b1;
        a_in[0 +: 24] = 24'h000003;
        b_in[0 +: 24] = 24'h000005;
        req = 4'b0001;
        wait_gnt(4'b0001, lat);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        do_reset(1);
        mul_dead = 1'b0;
        repeat (3) @(negedge clk);

`ifdef MUL_ARB_TIMEOUT_EN
        // Dead multiplier: timeout response, then a fresh FLUSH
        mul_dead = 1'b1;
        a_in[72 +: 24] = 24'd5;
        b_in[72 +: 24] = 24'd5;
        sb.push_back(mk(4'b1000, 48'd0, 1'b1));
        req = 4'b1000;
        wait_gnt(4'b1000, lat);
        req = 4'b0000;
        wait_done(lat);
        chk("timeout_latency", 64'(lat), 64'd16);
        @(negedge clk);
        flush_check(-1);
        mul_dead = 1'b0;
        a_in[0 +: 24] = 24'd4;
        b_in[0 +: 24] = 24'd6;
        sb.push_back(mk(4'b0001, 48'd24, 1'b0));
        req = 4'b0001;
        wait_gnt(4'b0001, lat);
        req = 4'b0000;
        wait_done(lat);
        repeat (3) @(negedge clk);
`endif

        // req2 dropped the cycle after grant: completes once, no re-grant
        a_in[48 +: 24] = 24'd7;
        b_in[48 +: 24] = 24'd9;
        sb.push_back(mk(4'b0100, 48'd63, 1'b0));
        req = 4'b0100;
        wait_gnt(4'b0100, lat);
        @(negedge clk);
        req = 4'b0000;
        wait_done(lat);
        g2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt[2]) g2++;
        end
        chk("no_regrant_2", 64'(g2), 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
